rtc_bus_controller: RTL and testbench

RTC_BUS_CONTROLLER -- requirements
Module: rtc_bus_controller

---
 rtl/rtc_bus_controller_if.sv | 44 ++++
 rtl/rtc_bus_controller.sv | 177 +++++++++++++++++
 tb/tb_rtc_bus_controller.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_bus_controller_if.sv
// Bundles the signals between the host, the RTC bus controller and the RTC.
//
// Host handshake:
//   trabaje      transaction request (host -> controller)
//   lea_escriba  1 = read, 0 = write
//   direccion    RTC register address
//   dato_in      write data
//   rtc_work     busy flag (controller -> host)
//   tome         one-cycle pulse: dato_out holds fresh read data
//   dato_out     last byte read from the RTC
// Multiplexed RTC bus:
//   cs_n, rd_n, wr_n  active-low chip select and strobes
//   a_d          0 = address phase, 1 = data phase
//   ad_o, ad_oe  value driven on the AD bus and its output enable
//   ad_i         AD bus value returned by the RTC
//
// The master modport is the environment (host plus RTC). The slave modport is
// the controller.
interface rtc_bus_controller_if;
    logic       trabaje;
    logic       lea_escriba;
    logic [7:0] direccion;
    logic [7:0] dato_in;
    logic       rtc_work;
    logic       tome;
    logic [7:0] dato_out;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a_d;
    logic [7:0] ad_o;
    logic       ad_oe;
    logic [7:0] ad_i;

    modport master (
        output trabaje, lea_escriba, direccion, dato_in, ad_i,
        input  rtc_work, tome, dato_out, cs_n, rd_n, wr_n, a_d, ad_o, ad_oe
    );

    modport slave (
        input  trabaje, lea_escriba, direccion, dato_in, ad_i,
        output rtc_work, tome, dato_out, cs_n, rd_n, wr_n, a_d, ad_o, ad_oe
    );
endinterface

// File: rtl/rtc_bus_controller.sv
// Multiplexed-bus RTC controller. One request runs an address phase (address
// always written), a gap with cs_n high, then a data phase that either writes
// dato_in or reads the RTC into dato_out.
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    rtc_bus_controller_if.slave (host handshake and RTC bus)
//
// Parameters (all must be >= 1):
//   T_SETUP  cycles from address/data valid to strobe assertion
//   T_PULSE  cycles a strobe is held low
//   T_HOLD   cycles address/data stay driven after strobe release
//   T_GAP    cycles cs_n is high between address and data phases
module rtc_bus_controller #(
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_PULSE = 7,
    parameter int unsigned T_HOLD  = 2,
    parameter int unsigned T_GAP   = 4
) (
    input logic             clk,
    input logic             reset,
    rtc_bus_controller_if.slave bus
);

    localparam int unsigned T_MAX_A = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int unsigned T_MAX_B = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
    localparam int unsigned T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    // The counter holds duration-1, so it never needs to reach T_MAX.
    localparam int unsigned CNT_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_A_SETUP  = 4'd1;
    localparam logic [3:0] S_A_STROBE = 4'd2;
    localparam logic [3:0] S_A_HOLD   = 4'd3;
    localparam logic [3:0] S_GAP      = 4'd4;
    localparam logic [3:0] S_D_SETUP  = 4'd5;
    localparam logic [3:0] S_D_STROBE = 4'd6;
    localparam logic [3:0] S_D_HOLD   = 4'd7;
    localparam logic [3:0] S_DONE     = 4'd8;

    function automatic logic [CNT_W-1:0] load_of(input int unsigned t);
        return CNT_W'(t - 1);
    endfunction

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rd_q, rd_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       data_q, data_d;

    logic       rtc_work_q, rtc_work_d;
    logic       tome_q, tome_d;
    logic [7:0] dato_out_q, dato_out_d;
    logic       cs_n_q, cs_n_d;
    logic       rd_n_q, rd_n_d;
    logic       wr_n_q, wr_n_d;
    logic       a_d_q, a_d_d;
    logic       ad_oe_q, ad_oe_d;
    logic [7:0] ad_o_q, ad_o_d;

    logic             last;
    logic [3:0]       nxt_state;
    logic [CNT_W-1:0] nxt_load;
    logic             in_a;
    logic             in_d;

    // Sequencing: every timed state hands over to a successor with a fresh
    // count when the shared down-counter reaches zero.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        addr_d    = addr_q;
        data_d    = data_q;
        last      = (cnt_q == '0);
        nxt_state = S_IDLE;
        nxt_load  = '0;

        case (state_q)
            S_A_SETUP:  begin nxt_state = S_A_STROBE; nxt_load = load_of(T_PULSE); end
            S_A_STROBE: begin nxt_state = S_A_HOLD;   nxt_load = load_of(T_HOLD);  end
            S_A_HOLD:   begin nxt_state = S_GAP;      nxt_load = load_of(T_GAP);   end
            S_GAP:      begin nxt_state = S_D_SETUP;  nxt_load = load_of(T_SETUP); end
            S_D_SETUP:  begin nxt_state = S_D_STROBE; nxt_load = load_of(T_PULSE); end
            S_D_STROBE: begin nxt_state = S_D_HOLD;   nxt_load = load_of(T_HOLD);  end
            S_D_HOLD:   begin nxt_state = S_DONE;     nxt_load = '0;               end
            default:    begin nxt_state = S_IDLE;     nxt_load = '0;               end
        endcase

        if (state_q == S_IDLE) begin
            // Requests are only looked at here, so a busy controller ignores them.
            if (bus.trabaje) begin
                state_d = S_A_SETUP;
                cnt_d   = load_of(T_SETUP);
                rd_d    = bus.lea_escriba;
                addr_d  = bus.direccion;
                data_d  = bus.dato_in;
            end
        end else if (state_q == S_DONE || state_q > S_DONE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (last) begin
            state_d = nxt_state;
            cnt_d   = nxt_load;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Outputs are decoded from the next state and registered, so each pin
    // already shows the new state's value in that state's first cycle.
    always_comb begin
        in_a = (state_d == S_A_SETUP) || (state_d == S_A_STROBE) || (state_d == S_A_HOLD);
        in_d = (state_d == S_D_SETUP) || (state_d == S_D_STROBE) || (state_d == S_D_HOLD);

        cs_n_d     = !(in_a || in_d);
        a_d_d      = !in_a;
        ad_oe_d    = in_a || (in_d && !rd_d);
        ad_o_d     = in_a ? addr_d : ((in_d && !rd_d) ? data_d : 8'h00);
        wr_n_d     = !((state_d == S_A_STROBE) || ((state_d == S_D_STROBE) && !rd_d));
        rd_n_d     = !((state_d == S_D_STROBE) && rd_d);
        rtc_work_d = (state_d != S_IDLE);
        tome_d     = (state_d == S_DONE) && rd_d;

        // Capture on the last strobe cycle while rd_n is still low.
        dato_out_d = dato_out_q;
        if ((state_q == S_D_STROBE) && last && rd_q) begin
            dato_out_d = bus.ad_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rd_q       <= 1'b0;
            addr_q     <= 8'h00;
            data_q     <= 8'h00;
            rtc_work_q <= 1'b0;
            tome_q     <= 1'b0;
            dato_out_q <= 8'h00;
            cs_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            a_d_q      <= 1'b1;
            ad_oe_q    <= 1'b0;
            ad_o_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rtc_work_q <= rtc_work_d;
            tome_q     <= tome_d;
            dato_out_q <= dato_out_d;
            cs_n_q     <= cs_n_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            a_d_q      <= a_d_d;
            ad_oe_q    <= ad_oe_d;
            ad_o_q     <= ad_o_d;
        end
    end

    assign bus.rtc_work = rtc_work_q;
    assign bus.tome     = tome_q;
    assign bus.dato_out = dato_out_q;
    assign bus.cs_n     = cs_n_q;
    assign bus.rd_n     = rd_n_q;
    assign bus.wr_n     = wr_n_q;
    assign bus.a_d      = a_d_q;
    assign bus.ad_oe    = ad_oe_q;
    assign bus.ad_o     = ad_o_q;

endmodule

// File: tb/tb_rtc_bus_controller.sv
// Directed bench for rtc_bus_controller at default timing (2/7/2/4).
// Expected figures: busy 27 cycles, each strobe low 7 cycles, gap 4 cycles.
module tb_rtc_bus_controller;

    logic clk = 1'b0;
    logic reset;
    logic [7:0] rtc_val;

    always #5 clk = ~clk;

    rtc_bus_controller_if bus ();

    // RTC model: returns rtc_val only while rd_n is low, filler otherwise.
    assign bus.ad_i = (bus.rd_n === 1'b0) ? rtc_val : 8'hAA;

    rtc_bus_controller #(
        .T_SETUP (2),
        .T_PULSE (7),
        .T_HOLD  (2),
        .T_GAP   (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Per-transaction statistics gathered by measure().
    int   busy, wr_a, wr_d, rd_lo, tome_n, tome_bad, oe_data, gap_len, cur_run;
    int   a_bad, d_bad;
    logic first_busy;
    logic ended;
    logic found;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Protocol checker, every cycle away from the active edge.
    always @(negedge clk) begin
        total++;
        assert (!(bus.rd_n === 1'b0 && bus.wr_n === 1'b0)) else begin
            bad++;
            $error("FAIL strobe_overlap: rd_n=%b wr_n=%b required not both 0", bus.rd_n, bus.wr_n);
        end
        total++;
        assert (!(bus.rd_n === 1'b0 && bus.ad_oe !== 1'b0)) else begin
            bad++;
            $error("FAIL oe_during_rd: ad_oe=%b required 0 while rd_n=0", bus.ad_oe);
        end
    end

    // Runs from the edge that accepts a request until rtc_work is seen low.
    // hold keeps trabaje high; poke re-requests with another address mid-way.
    task automatic measure(input logic hold, input int poke,
                           input logic [7:0] exp_a, input logic [7:0] exp_d);
        busy = 0; wr_a = 0; wr_d = 0; rd_lo = 0; tome_n = 0; tome_bad = 0;
        oe_data = 0; gap_len = 0; cur_run = 0; a_bad = 0; d_bad = 0;
        first_busy = 1'b0; ended = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                bus.trabaje = hold;
                first_busy  = bus.rtc_work;
            end
            if (bus.rtc_work !== 1'b1) begin
                ended = 1'b1;
                break;
            end
            busy++;
            if (bus.wr_n === 1'b0 && bus.a_d === 1'b0) begin
                wr_a++;
                if (bus.ad_o !== exp_a) a_bad++;
            end
            if (bus.wr_n === 1'b0 && bus.a_d === 1'b1) begin
                wr_d++;
                if (bus.ad_o !== exp_d) d_bad++;
            end
            if (bus.rd_n === 1'b0) rd_lo++;
            if (bus.tome === 1'b1) begin
                tome_n++;
                if (bus.cs_n !== 1'b1 || bus.ad_oe !== 1'b0) tome_bad++;
            end
            if (bus.a_d === 1'b1 && bus.cs_n === 1'b0 && bus.ad_oe === 1'b1) oe_data++;
            if (bus.cs_n === 1'b1) begin
                cur_run++;
            end else begin
                if (cur_run > 0) gap_len = cur_run;
                cur_run = 0;
            end
            if (i == poke) begin
                bus.trabaje   = 1'b1;
                bus.direccion = 8'h33;
                bus.dato_in   = 8'h99;
            end else if (i == poke + 1) begin
                bus.trabaje = 1'b0;
            end
        end
        check("txn_terminates", 32'(ended), 32'd1);
    endtask

    initial begin
        reset           = 1'b1;
        rtc_val         = 8'h59;
        bus.trabaje     = 1'b0;
        bus.lea_escriba = 1'b0;
        bus.direccion   = 8'h00;
        bus.dato_in     = 8'h00;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_rtc_work", 32'(bus.rtc_work), 32'd0);
        check("rst_tome",     32'(bus.tome),     32'd0);
        check("rst_dato_out", 32'(bus.dato_out), 32'h00);
        check("rst_cs_n",     32'(bus.cs_n),     32'd1);
        check("rst_rd_n",     32'(bus.rd_n),     32'd1);
        check("rst_wr_n",     32'(bus.wr_n),     32'd1);
        check("rst_a_d",      32'(bus.a_d),      32'd1);
        check("rst_ad_oe",    32'(bus.ad_oe),    32'd0);
        check("rst_ad_o",     32'(bus.ad_o),     32'h00);

        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_rtc_work", 32'(bus.rtc_work), 32'd0);

        // Write 0x45 to register 0x21
        bus.trabaje = 1'b1; bus.lea_escriba = 1'b0;
        bus.direccion = 8'h21; bus.dato_in = 8'h45;
        measure(1'b0, -10, 8'h21, 8'h45);
        check("wr_first_busy", 32'(first_busy), 32'd1);
        check("wr_busy_len",   32'(busy),  32'd27);
        check("wr_addr_strb",  32'(wr_a),  32'd7);
        check("wr_data_strb",  32'(wr_d),  32'd7);
        check("wr_addr_val",   32'(a_bad), 32'd0);
        check("wr_data_val",   32'(d_bad), 32'd0);
        check("wr_no_rd",      32'(rd_lo), 32'd0);
        check("wr_no_tome",    32'(tome_n), 32'd0);
        check("wr_gap_len",    32'(gap_len), 32'd4);

        // Read register 0x22, RTC returns 0x59
        bus.trabaje = 1'b1; bus.lea_escriba = 1'b1; bus.direccion = 8'h22;
        measure(1'b0, -10, 8'h22, 8'h00);
        check("rd_busy_len",   32'(busy),     32'd27);
        check("rd_addr_strb",  32'(wr_a),     32'd7);
        check("rd_addr_val",   32'(a_bad),    32'd0);
        check("rd_no_wr_data", 32'(wr_d),     32'd0);
        check("rd_strb_len",   32'(rd_lo),    32'd7);
        check("rd_tome_once",  32'(tome_n),   32'd1);
        check("rd_tome_done",  32'(tome_bad), 32'd0);
        check("rd_oe_data",    32'(oe_data),  32'd0);
        check("rd_gap_len",    32'(gap_len),  32'd4);
        check("rd_dato_out",   32'(bus.dato_out), 32'h59);

        // Request at cycle 10 of a busy write must be ignored
        bus.trabaje = 1'b1; bus.lea_escriba = 1'b0;
        bus.direccion = 8'h21; bus.dato_in = 8'h45;
        measure(1'b0, 10, 8'h21, 8'h45);
        check("bz_busy_len",  32'(busy),  32'd27);
        check("bz_addr_strb", 32'(wr_a),  32'd7);
        check("bz_addr_val",  32'(a_bad), 32'd0);
        check("bz_data_val",  32'(d_bad), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bz_stays_idle", 32'(bus.rtc_work), 32'd0);
        end
        check("bz_dato_held", 32'(bus.dato_out), 32'h59);

        // Back-to-back with trabaje held high
        bus.trabaje = 1'b1; bus.lea_escriba = 1'b0;
        bus.direccion = 8'h21; bus.dato_in = 8'h45;
        measure(1'b1, -10, 8'h21, 8'h45);
        check("b2b_busy1", 32'(busy), 32'd27);
        bus.direccion = 8'h5A; bus.dato_in = 8'h3C;
        measure(1'b0, -10, 8'h5A, 8'h3C);
        check("b2b_one_idle",  32'(first_busy), 32'd1);
        check("b2b_busy2",     32'(busy),  32'd27);
        check("b2b_addr_val",  32'(a_bad), 32'd0);
        check("b2b_data_val",  32'(d_bad), 32'd0);
        check("b2b_data_strb", 32'(wr_d),  32'd7);

        // Reset during D_STROBE of a read
        rtc_val = 8'h77;
        bus.trabaje = 1'b1; bus.lea_escriba = 1'b1; bus.direccion = 8'h22;
        @(posedge clk); #1;
        bus.trabaje = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.rd_n === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        check("ab_reached_strobe", 32'(found), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        bus.trabaje = 1'b1;
        @(posedge clk); #1;
        check("ab_rd_n",     32'(bus.rd_n),     32'd1);
        check("ab_cs_n",     32'(bus.cs_n),     32'd1);
        check("ab_ad_oe",    32'(bus.ad_oe),    32'd0);
        check("ab_rtc_work", 32'(bus.rtc_work), 32'd0);
        check("ab_dato_out", 32'(bus.dato_out), 32'h00);
        check("ab_tome",     32'(bus.tome),     32'd0);
        check("ab_ad_o",     32'(bus.ad_o),     32'h00);
        reset = 1'b0;
        bus.trabaje = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("ab_no_tome", 32'(bus.tome),     32'd0);
            check("ab_idle",    32'(bus.rtc_work), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
